// File: rtl/bcd_counter_display.sv
// rtl/bcd_counter_display.sv - N-digit BCD up/down counter with prescaler and multiplexed 7-segment display
module bcd_counter_display #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_HZ     = 100_000_000,
   parameter int COUNT_HZ   = 1,
   parameter int SCAN_DIV   = 100_000,
   parameter int BLANK_LZ   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    up_down,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    tick,
   output logic                    wrap,
   output logic [6:0]              LED_out,
   output logic [NUM_DIGITS-1:0]   LED_anode
);

   localparam int TICK_DIV = CLK_HZ / COUNT_HZ;
   localparam int PW       = $clog2(TICK_DIV);
   localparam int SW       = $clog2(SCAN_DIV);
   localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           prescaler;
   logic [SW-1:0]           scan_timer;
   logic [IW-1:0]           scan_index;
   logic                    terminal;
   logic [4*NUM_DIGITS-1:0] stepped;
   logic                    carry;
   logic [3:0]              digit;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    all_zero;
   logic [3:0]              cur_digit;
   logic [NUM_DIGITS-1:0]   anode_onehot;

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0001100;
         default: seg = 7'b1111111;
      endcase
   endfunction

   assign terminal = en && (prescaler == PRE_LAST);

   // Ripple the carry/borrow through the digits; what leaves the top digit is the wrap
   always_comb begin
      stepped = count_bcd;
      carry   = 1'b1;
      digit   = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit = count_bcd[4*i +: 4];
         if (carry) begin
            if (up_down) begin
               if (digit == 4'd9) begin
                  stepped[4*i +: 4] = 4'd0;
               end else begin
                  stepped[4*i +: 4] = digit + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (digit == 4'd0) begin
                  stepped[4*i +: 4] = 4'd9;
               end else begin
                  stepped[4*i +: 4] = digit - 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
   end

   // A digit is a leading zero when it and every digit above it are zero
   always_comb begin
      blank    = '0;
      all_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero && (count_bcd[4*i +: 4] == 4'd0);
         blank[i] = (BLANK_LZ != 0) && all_zero;
      end
   end

   assign cur_digit    = count_bcd[4*scan_index +: 4];
   assign anode_onehot = NUM_DIGITS'(1) << scan_index;

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler  <= '0;
         count_bcd  <= '0;
         tick       <= 1'b0;
         wrap       <= 1'b0;
         scan_timer <= '0;
         scan_index <= '0;
         LED_anode  <= '1;
         LED_out    <= 7'b1111111;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (clear) begin
            count_bcd <= '0;
            prescaler <= '0;
         end else if (en) begin
            if (terminal) begin
               prescaler <= '0;
               count_bcd <= stepped;
               tick      <= 1'b1;
               wrap      <= carry;
            end else begin
               prescaler <= prescaler + 1'b1;
            end
         end

         if (scan_timer == SCAN_LAST) begin
            scan_timer <= '0;
            scan_index <= (scan_index == IDX_LAST) ? '0 : scan_index + 1'b1;
         end else begin
            scan_timer <= scan_timer + 1'b1;
         end

         LED_anode <= ~anode_onehot;
         LED_out   <= blank[scan_index] ? 7'b1111111 : seg(cur_digit);
      end
   end

endmodule

// File: tb/tb_bcd_counter_display.sv
// tb/tb_bcd_counter_display.sv - directed bench for bcd_counter_display (2 digits, TICK_DIV=20, SCAN_DIV=4)
module tb_bcd_counter_display;

   logic       clk = 1'b0;
   logic       rst, en, up_down, clear;
   logic [7:0] count_bcd, count_bcd_b;
   logic       tick, wrap, tick_b, wrap_b;
   logic [6:0] LED_out, LED_out_b;
   logic [1:0] LED_anode, LED_anode_b;

   int checks   = 0;
   int failures = 0;

   localparam logic [6:0] SEG0 = 7'b0000001;
   localparam logic [6:0] SEG2 = 7'b0010010;
   localparam logic [6:0] SEG4 = 7'b1001100;
   localparam logic [6:0] SEG7 = 7'b0001111;
   localparam logic [6:0] DARK = 7'b1111111;

   always #5 clk = ~clk;

   bcd_counter_display #(.NUM_DIGITS(2), .CLK_HZ(20), .COUNT_HZ(1), .SCAN_DIV(4), .BLANK_LZ(0)) dut (
      .clk(clk), .rst(rst), .en(en), .up_down(up_down), .clear(clear),
      .count_bcd(count_bcd), .tick(tick), .wrap(wrap), .LED_out(LED_out), .LED_anode(LED_anode)
   );

   bcd_counter_display #(.NUM_DIGITS(2), .CLK_HZ(20), .COUNT_HZ(1), .SCAN_DIV(4), .BLANK_LZ(1)) dut_blank (
      .clk(clk), .rst(rst), .en(en), .up_down(up_down), .clear(clear),
      .count_bcd(count_bcd_b), .tick(tick_b), .wrap(wrap_b), .LED_out(LED_out_b), .LED_anode(LED_anode_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of edges until tick is seen, or -1 on timeout
   task automatic wait_tick(output int n);
      n = -1;
      for (int c = 1; c <= 200; c++) begin
         step();
         if (tick) begin
            n = c;
            break;
         end
      end
      if (n < 0) check("tick_timeout", 0, 1);
   endtask

   task automatic goto_count(input logic [7:0] target);
      int n;
      en = 1'b1;
      for (int t = 0; t < 120; t++) begin
         wait_tick(n);
         if (n < 0 || count_bcd == target) break;
      end
      check("goto_count", count_bcd, target);
   endtask

   initial begin
      int n, bad, wraps, ticks_seen, last_change;
      logic [1:0] prev;

      rst = 1'b1; en = 1'b1; up_down = 1'b1; clear = 1'b0;

      // Reset state
      for (int c = 0; c < 3; c++) begin
         step();
         check("rst_anode", LED_anode, 2'b11);
         check("rst_out", LED_out, DARK);
      end
      check("rst_count", count_bcd, 8'h00);
      check("rst_tick_wrap", {tick, wrap}, 2'b00);
      rst = 1'b0;

      // First display and first tick
      step();
      check("first_anode", LED_anode, 2'b10);
      check("first_out", LED_out, SEG0);
      wait_tick(n);
      check("first_tick_latency", n + 1, 20);
      check("first_count", count_bcd, 8'h01);
      check("first_wrap", wrap, 1'b0);

      // Up count to 99, then wrap
      bad = 0; wraps = 0;
      for (int k = 2; k <= 99; k++) begin
         wait_tick(n);
         if (n != 20) bad++;
         if (wrap) wraps++;
         check("up_count", count_bcd, ((k / 10) << 4) | (k % 10));
      end
      check("up_period", bad, 0);
      check("up_no_wrap", wraps, 0);
      wait_tick(n);
      check("up_wrap_period", n, 20);
      check("up_wrap_count", count_bcd, 8'h00);
      check("up_wrap_flag", wrap, 1'b1);

      // Down across zero
      up_down = 1'b0;
      wait_tick(n);
      check("down_wrap_count", count_bcd, 8'h99);
      check("down_wrap_flag", wrap, 1'b1);
      wait_tick(n);
      check("down_count", count_bcd, 8'h98);
      check("down_no_wrap", wrap, 1'b0);

      // Enable freeze at prescaler=10
      ticks_seen = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (tick) ticks_seen++;
      end
      en = 1'b0;
      bad = 0;
      for (int c = 0; c < 7; c++) begin
         step();
         if (tick) ticks_seen++;
         if (count_bcd != 8'h98) bad++;
      end
      check("freeze_no_tick", ticks_seen, 0);
      check("freeze_count", bad, 0);
      en = 1'b1;
      wait_tick(n);
      check("resume_latency", n, 10);
      check("resume_count", count_bcd, 8'h97);

      // Clear beats the terminal edge
      goto_count(8'h57);
      ticks_seen = 0;
      for (int c = 0; c < 19; c++) begin
         step();
         if (tick) ticks_seen++;
      end
      check("pre_clear_no_tick", ticks_seen, 0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear_count", count_bcd, 8'h00);
      check("clear_tick_wrap", {tick, wrap}, 2'b00);
      wait_tick(n);
      check("clear_latency", n, 20);
      check("after_clear_count", count_bcd, 8'h99);
      check("after_clear_wrap", wrap, 1'b1);

      // Display scan with count 42
      goto_count(8'h42);
      en = 1'b0;
      step();
      prev = LED_anode;
      last_change = -1;
      for (int c = 0; c < 24; c++) begin
         step();
         check("scan_onehot", (LED_anode == 2'b10) || (LED_anode == 2'b01), 1);
         check("scan_out", LED_out, (LED_anode == 2'b10) ? SEG2 : SEG4);
         check("scan_out_b", LED_out_b, (LED_anode_b == 2'b10) ? SEG2 : SEG4);
         if (LED_anode != prev) begin
            if (last_change >= 0) check("scan_period", c - last_change, 4);
            last_change = c;
            prev = LED_anode;
         end
      end
      check("scan_changes_seen", last_change >= 0, 1);

      // Leading-zero blanking with count 07
      goto_count(8'h07);
      en = 1'b0;
      step();
      for (int c = 0; c < 12; c++) begin
         step();
         check("blank_out", LED_out_b, (LED_anode_b == 2'b01) ? DARK : SEG7);
         check("noblank_out", LED_out, (LED_anode == 2'b01) ? SEG0 : SEG7);
      end

      // Mid-scan reset
      step();
      rst = 1'b1;
      step();
      check("midrst_anode", LED_anode, 2'b11);
      check("midrst_out", LED_out, DARK);
      check("midrst_count", count_bcd, 8'h00);
      rst = 1'b0;
      step();
      check("post_rst_anode", LED_anode, 2'b10);
      check("post_rst_out", LED_out, SEG0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
